glitch_sequencer: RTL and testbench

Sequences the glitch output and target-reset output from the configuration registers and one-cycle strobes produced by the UART command handler. It sits between the command handler and the board pins. It supports three start sources:
- an immediate fire;
- a target-reset-then-fire flow;
- arming followed by an external trigger.

Once started, it produces `num_pulses` glitch pulses of `width` cycles each, separated by `spacing` cycles, after a `delay`.

---
 rtl/glitch_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_glitch_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: turns command-handler strobes and latched configuration
// into timed glitch pulses and a target reset. A sequence can start at once,
// after a target reset, or on an external trigger edge once armed.
module glitch_sequencer #(
  parameter int TRIG_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] delay_i,
  input  logic [7:0]  width_i,
  input  logic [7:0]  num_pulses_i,
  input  logic [15:0] pulse_spacing_i,
  input  logic [15:0] reset_length_i,
  input  logic        pulse_en_i,
  input  logic        reset_en_i,
  input  logic        arm_i,
  input  logic        trigger_i,
  output logic        glitch_o,
  output logic        target_rst_o,
  output logic        armed_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {IDLE, ARMED, TRESET, DELAY, PULSE, SPACE} state_t;

  // Everything the state machine updates in one step, bundled so the
  // start-of-sequence helpers can fill it in as a unit.
  typedef struct packed {
    state_t      st;
    logic [15:0] cnt;
    logic [7:0]  wc;
    logic [7:0]  pc;
    logic        done;
  } step_t;

  state_t                      r_state;
  logic [15:0]                 r_cnt;
  logic [7:0]                  r_widthCnt;
  logic [7:0]                  r_pulseCnt;
  logic [15:0]                 r_delay;
  logic [7:0]                  r_width;
  logic [7:0]                  r_numPulses;
  logic [15:0]                 r_spacing;
  logic [TRIG_SYNC_STAGES-1:0] r_trigSync;
  logic                        r_trigHist;
  logic                        r_doneStage;
  logic                        r_glitch;
  logic                        r_targetRst;
  logic                        r_armed;
  logic                        r_busy;
  logic                        r_done;

  step_t w_next;
  logic  w_latch;
  logic  w_trigRise;

  // Leaving the delay: either the first pulse begins, or with nothing to
  // emit the sequence ends right here.
  function automatic step_t afterDelay(input logic [7:0] w, input logic [7:0] n,
                                       input step_t cur);
    step_t s;
    s = cur;
    if (w == 8'd0 || n == 8'd0) begin
      s.st   = IDLE;
      s.done = 1'b1;
    end else begin
      s.st = PULSE;
      s.wc = w - 8'd1;
      s.pc = n - 8'd1;
    end
    return s;
  endfunction

  // Entering the delay phase; a zero delay skips straight past it so the
  // first rise still lands one cycle after the start.
  function automatic step_t enterDelay(input logic [15:0] d, input logic [7:0] w,
                                       input logic [7:0] n, input step_t cur);
    step_t s;
    if (d == 16'd0) begin
      s = afterDelay(w, n, cur);
    end else begin
      s     = cur;
      s.st  = DELAY;
      s.cnt = d - 16'd1;
    end
    return s;
  endfunction

  assign w_trigRise = r_trigSync[TRIG_SYNC_STAGES-1] & ~r_trigHist;

  // Next-state logic; counters are loaded with length-1 and leave at zero,
  // so the full 0..max range never needs an extra counter bit.
  always_comb begin
    w_next  = '{st: r_state, cnt: r_cnt, wc: r_widthCnt, pc: r_pulseCnt, done: 1'b0};
    w_latch = 1'b0;
    case (r_state)
      IDLE, ARMED: begin
        if (reset_en_i) begin
          w_latch = 1'b1;
          if (reset_length_i == 16'd0) begin
            w_next = enterDelay(delay_i, width_i, num_pulses_i, w_next);
          end else begin
            w_next.st  = TRESET;
            w_next.cnt = reset_length_i - 16'd1;
          end
        end else if (pulse_en_i) begin
          w_latch = 1'b1;
          w_next  = enterDelay(delay_i, width_i, num_pulses_i, w_next);
        end else if (r_state == IDLE && arm_i) begin
          w_next.st = ARMED;
        end else if (r_state == ARMED && w_trigRise) begin
          w_latch = 1'b1;
          w_next  = enterDelay(delay_i, width_i, num_pulses_i, w_next);
        end
      end
      TRESET: begin
        if (r_cnt == 16'd0) w_next = enterDelay(r_delay, r_width, r_numPulses, w_next);
        else                w_next.cnt = r_cnt - 16'd1;
      end
      DELAY: begin
        if (r_cnt == 16'd0) w_next = afterDelay(r_width, r_numPulses, w_next);
        else                w_next.cnt = r_cnt - 16'd1;
      end
      PULSE: begin
        if (r_widthCnt != 8'd0) begin
          w_next.wc = r_widthCnt - 8'd1;
        end else if (r_pulseCnt == 8'd0) begin
          w_next.st   = IDLE;
          w_next.done = 1'b1;
        end else begin
          w_next.pc = r_pulseCnt - 8'd1;
          w_next.wc = r_width - 8'd1;
          if (r_spacing == 16'd0) begin
            w_next.st = PULSE;
          end else begin
            w_next.st  = SPACE;
            w_next.cnt = r_spacing - 16'd1;
          end
        end
      end
      SPACE: begin
        if (r_cnt == 16'd0) begin
          w_next.st = PULSE;
          w_next.wc = r_width - 8'd1;
        end else begin
          w_next.cnt = r_cnt - 16'd1;
        end
      end
      default: w_next.st = IDLE;
    endcase
  end

  // Trigger synchronizer plus history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trigSync <= '0;
      r_trigHist <= 1'b0;
    end else begin
      r_trigSync <= {r_trigSync[TRIG_SYNC_STAGES-2:0], trigger_i};
      r_trigHist <= r_trigSync[TRIG_SYNC_STAGES-1];
    end
  end

  // State, counters and configuration snapshot taken on the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_widthCnt  <= '0;
      r_pulseCnt  <= '0;
      r_delay     <= '0;
      r_width     <= '0;
      r_numPulses <= '0;
      r_spacing   <= '0;
    end else begin
      r_state    <= w_next.st;
      r_cnt      <= w_next.cnt;
      r_widthCnt <= w_next.wc;
      r_pulseCnt <= w_next.pc;
      if (w_latch) begin
        r_delay     <= delay_i;
        r_width     <= width_i;
        r_numPulses <= num_pulses_i;
        r_spacing   <= pulse_spacing_i;
      end
    end
  end

  // Registered pin outputs; done is staged twice so it lines up with the
  // final falling edge of the glitch output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_glitch    <= 1'b0;
      r_targetRst <= 1'b0;
      r_armed     <= 1'b0;
      r_busy      <= 1'b0;
      r_doneStage <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_glitch    <= (r_state == PULSE);
      r_targetRst <= (r_state == TRESET);
      r_armed     <= (r_state == ARMED);
      r_busy      <= (r_state != IDLE);
      r_doneStage <= w_next.done;
      r_done      <= r_doneStage;
    end
  end

  assign glitch_o     = r_glitch;
  assign target_rst_o = r_targetRst;
  assign armed_o      = r_armed;
  assign busy_o       = r_busy;
  assign done_o       = r_done;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: each task drives one scenario and
// compares the packed output vector {glitch, target_rst, armed, busy, done}
// against hand-derived cycle-by-cycle expectations.
module tb_glitch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] delay_i = '0;
  logic [7:0]  width_i = '0;
  logic [7:0]  num_pulses_i = '0;
  logic [15:0] pulse_spacing_i = '0;
  logic [15:0] reset_length_i = '0;
  logic        pulse_en_i = 1'b0;
  logic        reset_en_i = 1'b0;
  logic        arm_i = 1'b0;
  logic        trigger_i = 1'b0;
  logic        glitch_o, target_rst_o, armed_o, busy_o, done_o;
  logic [4:0]  outs;
  logic [4:0]  exp;
  int          checks = 0;
  int          errors = 0;

  glitch_sequencer #(.TRIG_SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .delay_i(delay_i), .width_i(width_i), .num_pulses_i(num_pulses_i),
    .pulse_spacing_i(pulse_spacing_i), .reset_length_i(reset_length_i),
    .pulse_en_i(pulse_en_i), .reset_en_i(reset_en_i), .arm_i(arm_i),
    .trigger_i(trigger_i),
    .glitch_o(glitch_o), .target_rst_o(target_rst_o), .armed_o(armed_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  assign outs = {glitch_o, target_rst_o, armed_o, busy_o, done_o};

  always #5 clk = ~clk;

  // One-cycle strobe; returns 1ns after the sampling edge S, so the next
  // negedge shows the outputs "after S".
  task automatic applyStimulus(input logic p, input logic r, input logic a);
    @(negedge clk);
    pulse_en_i = p; reset_en_i = r; arm_i = a;
    @(posedge clk);
    #1;
    pulse_en_i = 1'b0; reset_en_i = 1'b0; arm_i = 1'b0;
  endtask

  task automatic setCfg(input logic [15:0] d, input logic [7:0] w, input logic [7:0] n,
                        input logic [15:0] p, input logic [15:0] rl);
    delay_i = d; width_i = w; num_pulses_i = n; pulse_spacing_i = p; reset_length_i = rl;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (outs !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset got %b want %b", outs, 5'b00000);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (outs !== 5'b00000) begin
        errors++;
        $display("[TB] FAIL reset_idle k=%0d got %b want %b", k, outs, 5'b00000);
      end
    end
  endtask

  task automatic test_pulse_train;
    setCfg(16'd5, 8'd3, 8'd2, 16'd4, 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      exp = {((k >= 6 && k <= 8) || (k >= 13 && k <= 15)), 1'b0, 1'b0,
             (k >= 1 && k <= 15), (k == 16)};
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL pulse_train k=%0d got %b want %b", k, outs, exp);
      end
    end
  endtask

  task automatic test_reset_flow;
    setCfg(16'd0, 8'd1, 8'd1, 16'd0, 16'd10);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      exp = {(k == 11), (k >= 1 && k <= 10), 1'b0, (k >= 1 && k <= 11), (k == 12)};
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL reset_flow k=%0d got %b want %b", k, outs, exp);
      end
    end
    setCfg(16'd1, 8'd1, 8'd1, 16'd0, 16'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      exp = {(k == 2), 1'b0, 1'b0, (k >= 1 && k <= 2), (k == 3)};
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL reset_len0 k=%0d got %b want %b", k, outs, exp);
      end
    end
  endtask

  task automatic test_zero_width;
    for (int v = 0; v < 2; v++) begin
      if (v == 0) setCfg(16'd7, 8'd0, 8'd2, 16'd1, 16'd0);
      else        setCfg(16'd7, 8'd3, 8'd0, 16'd1, 16'd0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int k = 0; k <= 11; k++) begin
        @(negedge clk);
        exp = {1'b0, 1'b0, 1'b0, (k >= 1 && k <= 7), (k == 8)};
        checks++;
        if (outs !== exp) begin
          errors++;
          $display("[TB] FAIL zero_width v=%0d k=%0d got %b want %b", v, k, outs, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    setCfg(16'd1, 8'd2, 8'd3, 16'd0, 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      exp = {(k >= 2 && k <= 7), 1'b0, 1'b0, (k >= 1 && k <= 7), (k == 8)};
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL back_to_back k=%0d got %b want %b", k, outs, exp);
      end
      if (k == 3) begin
        pulse_en_i = 1'b1; arm_i = 1'b1; reset_en_i = 1'b1;
        setCfg(16'd0, 8'd9, 8'd9, 16'd5, 16'd4);
      end else if (k == 4) begin
        pulse_en_i = 1'b0; arm_i = 1'b0; reset_en_i = 1'b0;
      end
    end
  endtask

  task automatic test_trigger;
    trigger_i = 1'b0;
    setCfg(16'd3, 8'd2, 8'd1, 16'd0, 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (outs !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL arm_lat0 got %b want %b", outs, 5'b00000);
    end
    @(negedge clk);
    checks++;
    if (outs !== 5'b00110) begin
      errors++;
      $display("[TB] FAIL arm_lat1 got %b want %b", outs, 5'b00110);
    end
    trigger_i = 1'b1;
    @(posedge clk);
    for (int m = 0; m <= 10; m++) begin
      @(negedge clk);
      exp = {(m == 6 || m == 7), 1'b0, (m <= 2), (m <= 7), (m == 8)};
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL trigger m=%0d got %b want %b", m, outs, exp);
      end
    end
    // Trigger is still high: arming must wait for a fresh edge.
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int j = 0; j <= 9; j++) begin
      @(negedge clk);
      exp = {1'b0, 1'b0, (j >= 1), (j >= 1), 1'b0};
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL trig_held j=%0d got %b want %b", j, outs, exp);
      end
      arm_i = (j == 4);
    end
    setCfg(16'd2, 8'd1, 8'd1, 16'd0, 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      exp = {(k == 3), 1'b0, (k == 0), (k <= 3), (k == 4)};
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL arm_cancel k=%0d got %b want %b", k, outs, exp);
      end
    end
    trigger_i = 1'b0;
  endtask

  task automatic test_rst_mid;
    setCfg(16'd0, 8'd50, 8'd1, 16'd0, 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      exp = {(k >= 1), 1'b0, 1'b0, (k >= 1), 1'b0};
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL rst_mid_pre k=%0d got %b want %b", k, outs, exp);
      end
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (outs !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL rst_mid got %b want %b", outs, 5'b00000);
    end
    rst = 1'b0;
    setCfg(16'd1, 8'd1, 8'd1, 16'd0, 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      exp = {(k == 2), 1'b0, 1'b0, (k >= 1 && k <= 2), (k == 3)};
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL rst_mid_restart k=%0d got %b want %b", k, outs, exp);
      end
    end
  endtask

  task automatic test_width_range;
    setCfg(16'd0, 8'd255, 8'd2, 16'd1, 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 514; k++) begin
      @(negedge clk);
      exp = {((k >= 1 && k <= 255) || (k >= 257 && k <= 511)), 1'b0, 1'b0,
             (k >= 1 && k <= 511), (k == 512)};
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL width_range k=%0d got %b want %b", k, outs, exp);
      end
    end
  endtask

  task automatic test_long_range;
    setCfg(16'd65535, 8'd255, 8'd1, 16'd0, 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 65792; k++) begin
      @(negedge clk);
      if (k == 65535 || k == 65536 || k == 65790 || k == 65791 || k == 65792) begin
        exp = {(k == 65536 || k == 65790), 1'b0, 1'b0, (k <= 65790), (k == 65791)};
        checks++;
        if (outs !== exp) begin
          errors++;
          $display("[TB] FAIL long_range k=%0d got %b want %b", k, outs, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pulse_train();
    test_reset_flow();
    test_zero_width();
    test_back_to_back();
    test_trigger();
    test_rst_mid();
    test_width_range();
    test_long_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
